// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, sizes and cell indexing for the 8x8 life engine
//
// Contents:
//   life_state_t : engine control states
//   GRID_N       : cells per row/column
//   GRID_W       : total cells (flattened grid width)
//   cell_idx     : flattened bit index of (row, col), bit r*8+c

package life_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAUSED  = 2'd1,
        RUNNING = 2'd2,
        HALTED  = 2'd3
    } life_state_t;

    localparam int GRID_N = 8;
    localparam int GRID_W = 64;

    function automatic int cell_idx(input int r, input int c);
        return r * GRID_N + c;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// rtl/life_next_gen.sv - combinational next-generation rule for a toroidal 8x8 grid
//
// Ports:
//   grid : current generation, bit r*8+c = row r, col c
//   next : generation that follows grid

module life_next_gen
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] grid,
    output logic [GRID_W-1:0] next
);

    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            // Neighbour coordinates wrap so the grid behaves as a torus.
            localparam int RU = (r + GRID_N - 1) % GRID_N;
            localparam int RD = (r + 1) % GRID_N;
            localparam int CL = (c + GRID_N - 1) % GRID_N;
            localparam int CR = (c + 1) % GRID_N;

            logic [3:0] sum;

            assign sum = {3'b000, grid[cell_idx(RU, CL)]} + {3'b000, grid[cell_idx(RU, c)]}
                       + {3'b000, grid[cell_idx(RU, CR)]} + {3'b000, grid[cell_idx(r,  CL)]}
                       + {3'b000, grid[cell_idx(r,  CR)]} + {3'b000, grid[cell_idx(RD, CL)]}
                       + {3'b000, grid[cell_idx(RD, c)]}  + {3'b000, grid[cell_idx(RD, CR)]};

            // Born with exactly 3, survives with 2 or 3.
            assign next[cell_idx(r, c)] = (sum == 4'd3) | (grid[cell_idx(r, c)] & (sum == 4'd2));
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - 8x8 Game-of-Life engine: seed load, run/step control, halt detection
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low
//   load      : 1-cycle pulse, capture seed and enter PAUSED (highest priority)
//   seed      : initial pattern
//   run       : level, 1 = free-run one generation every TICK_DIV cycles
//   step      : 1-cycle pulse, advance one generation while paused
//   grid      : current generation
//   gen_count : generations since last load, saturating
//   gen_valid : 1-cycle pulse in the cycle after grid changes
//   stable    : sticky, an update found next == grid
//   extinct   : sticky, the grid became all-zero
//   busy      : high while RUNNING

module life_grid_engine
    import life_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [63:0]       seed,
    input  logic              run,
    input  logic              step,
    output logic [63:0]       grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              gen_valid,
    output logic              stable,
    output logic              extinct,
    output logic              busy
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    life_state_t       state, state_d;
    logic [TICK_W-1:0] tick, tick_d;
    logic [63:0]       grid_d, next;
    logic [GEN_W-1:0]  gen_d;
    logic              valid_d, stable_d, extinct_d, do_update;

    life_next_gen u_next_gen (
        .grid (grid),
        .next (next)
    );

    always_comb begin
        state_d   = state;
        tick_d    = tick;
        grid_d    = grid;
        gen_d     = gen_count;
        valid_d   = 1'b0;
        stable_d  = stable;
        extinct_d = extinct;
        do_update = 1'b0;

        if (load) begin
            state_d   = PAUSED;
            tick_d    = '0;
            grid_d    = seed;
            gen_d     = '0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
        end else begin
            unique case (state)
                PAUSED: begin
                    if (run) state_d = RUNNING;
                    do_update = step;
                end
                RUNNING: begin
                    // Leaving RUNNING keeps tick so the period resumes where it stopped.
                    if (!run) begin
                        state_d = PAUSED;
                    end else if (tick == TICK_LAST) begin
                        tick_d    = '0;
                        do_update = 1'b1;
                    end else begin
                        tick_d = tick + 1'b1;
                    end
                end
                default: ;  // IDLE and HALTED only leave on load
            endcase
        end

        if (do_update) begin
            if (next == grid) begin
                stable_d = 1'b1;
                state_d  = HALTED;
            end else begin
                grid_d  = next;
                valid_d = 1'b1;
                if (gen_count != {GEN_W{1'b1}}) gen_d = gen_count + 1'b1;
                if (next == 64'd0) begin
                    extinct_d = 1'b1;
                    state_d   = HALTED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick      <= '0;
            grid      <= '0;
            gen_count <= '0;
            gen_valid <= 1'b0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
        end else begin
            state     <= state_d;
            tick      <= tick_d;
            grid      <= grid_d;
            gen_count <= gen_d;
            gen_valid <= valid_d;
            stable    <= stable_d;
            extinct   <= extinct_d;
        end
    end

    assign busy = (state == RUNNING);

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - self-checking bench for life_grid_engine

module tb_life_grid_engine;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 4;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              load  = 1'b0;
    logic              run   = 1'b0;
    logic              step  = 1'b0;
    logic [63:0]       seed  = 64'd0;
    logic [63:0]       grid;
    logic [GEN_W-1:0]  gen_count;
    logic              gen_valid, stable, extinct, busy;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model state
    localparam int M_IDLE = 0, M_PAUSED = 1, M_RUN = 2, M_HALT = 3;
    int          m_mode    = M_IDLE;
    int          m_tick    = 0;
    int          m_gen     = 0;
    logic [63:0] m_grid    = 64'd0;
    logic [63:0] m_nx;
    bit          m_valid   = 1'b0;
    bit          m_stable  = 1'b0;
    bit          m_extinct = 1'b0;
    bit          m_upd;

    life_grid_engine #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .run       (run),
        .step      (step),
        .grid      (grid),
        .gen_count (gen_count),
        .gen_valid (gen_valid),
        .stable    (stable),
        .extinct   (extinct),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE; m_tick = 0; m_gen = 0; m_grid = 64'd0;
            m_valid = 1'b0; m_stable = 1'b0; m_extinct = 1'b0;
        end else begin
            m_upd   = 1'b0;
            m_valid = 1'b0;
            if (load) begin
                m_grid = seed; m_gen = 0; m_tick = 0;
                m_stable = 1'b0; m_extinct = 1'b0; m_mode = M_PAUSED;
            end else if (m_mode == M_PAUSED) begin
                if (run) m_mode = M_RUN;
                m_upd = step;
            end else if (m_mode == M_RUN) begin
                if (!run) m_mode = M_PAUSED;
                else begin
                    m_tick = m_tick + 1;
                    if (m_tick == TICK_DIV) begin
                        m_tick = 0;
                        m_upd  = 1'b1;
                    end
                end
            end
            if (m_upd) begin
                m_nx = life_step(m_grid);
                if (m_nx == m_grid) begin
                    m_stable = 1'b1;
                    m_mode   = M_HALT;
                end else begin
                    m_grid  = m_nx;
                    m_valid = 1'b1;
                    if (m_gen < (1 << GEN_W) - 1) m_gen++;
                    if (m_nx == 64'd0) begin
                        m_extinct = 1'b1;
                        m_mode    = M_HALT;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grid", grid, m_grid);
            chk("gen_count", 64'(gen_count), 64'(m_gen));
            chk("gen_valid", 64'(gen_valid), 64'(m_valid));
            chk("stable", 64'(stable), 64'(m_stable));
            chk("extinct", 64'(extinct), 64'(m_extinct));
            chk("busy", 64'(busy), 64'(m_mode == M_RUN));
        end
    end

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (gen_valid) return;
        end
        cycles = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        logic [63:0] a, b;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_grid", grid, 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        step = 1'b1; run = 1'b1;
        @(negedge clk);
        step = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("idle_grid", grid, 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        do_load(BLINK_H);
        do_step();
        chk("blink_v", grid, BLINK_V);
        chk("blink_gen1", 64'(gen_count), 64'd1);
        chk("blink_valid", 64'(gen_valid), 64'd1);
        @(negedge clk);
        chk("blink_valid_drop", 64'(gen_valid), 64'd0);
        do_step();
        chk("blink_h", grid, BLINK_H);
        chk("blink_gen2", 64'(gen_count), 64'd2);

        do_load(64'h0000_0000_0000_0083);
        do_step();
        chk("wrap", grid, 64'h0100_0000_0000_0101);

        do_load(64'h0000_0000_0000_0303);
        do_step();
        chk("still_stable", 64'(stable), 64'd1);
        chk("still_gen", 64'(gen_count), 64'd0);
        chk("still_valid", 64'(gen_valid), 64'd0);
        do_step();
        run = 1'b1;
        repeat (8) @(negedge clk);
        run = 1'b0;
        chk("still_grid", grid, 64'h0000_0000_0000_0303);
        chk("still_busy", 64'(busy), 64'd0);

        do_load(64'd0);
        do_step();
        chk("zero_stable", 64'(stable), 64'd1);
        chk("zero_extinct", 64'(extinct), 64'd0);

        do_load(64'd1);
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("ext_busy_run", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("ext_grid", grid, 64'd0);
        chk("ext_flag", 64'(extinct), 64'd1);
        chk("ext_gen", 64'(gen_count), 64'd1);
        chk("ext_busy", 64'(busy), 64'd0);
        run = 1'b0;
        do_load(BLINK_H);
        chk("reload_extinct", 64'(extinct), 64'd0);
        chk("reload_stable", 64'(stable), 64'd0);

        run = 1'b1;
        wait_valid(20, n);
        chk("run_first_valid", 64'(n > 0), 64'd1);
        wait_valid(20, n);
        chk("run_period", 64'(n), 64'd4);
        repeat (2) @(negedge clk);
        run = 1'b0;
        repeat (10) @(negedge clk);
        run = 1'b1;
        wait_valid(20, n);
        chk("resume_latency", 64'(n), 64'd3);
        repeat (80) @(negedge clk);
        chk("gen_saturate", 64'(gen_count), 64'hF);
        run = 1'b0;
        @(negedge clk);

        seed = 64'h0000_0000_0000_0083;
        load = 1'b1; step = 1'b1;
        @(negedge clk);
        load = 1'b0; step = 1'b0;
        chk("prio_grid", grid, 64'h0000_0000_0000_0083);
        chk("prio_gen", 64'(gen_count), 64'd0);
        chk("prio_valid", 64'(gen_valid), 64'd0);

        do_load(BLINK_H);
        run = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_grid", grid, 64'd0);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_flags", {61'd0, gen_valid, stable, extinct}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        do_step();
        chk("arst_step_ignored", grid, 64'd0);

        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 11);
            if (op == 0) begin
                a = {$urandom, $urandom};
                b = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFFF;
                seed = a & b;
                load = 1'b1;
                step = ($urandom_range(0, 3) == 0);
            end else if (op <= 2) begin
                step = 1'b1;
            end else if (op == 3) begin
                run = ~run;
            end else if (op == 4) begin
                seed = BLINK_H;
                load = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            step = 1'b0;
        end
        run = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Consumes the 64-bit seed produced by the game-control FSM and evolves it as an 8x8 Conway Game-of-Life grid.
- Loads the seed on request, then advances one generation per tick while running, or on single-step pulses while paused.
- Feeds the display driver downstream.
- Halts itself on a still life or an extinct grid.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per generation while running. Minimum 2; benches use 4.
- GEN_W, 16: width of the generation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- load  in  1  1-cycle pulse; capture seed into grid
- seed  in  64  initial pattern; bit r*8+c = row r, col c
- run  in  1  level; 1 = free-run, 0 = pause
- step  in  1  1-cycle pulse; advance one generation while paused
- grid  out  64  current generation, registered
- gen_count  out  GEN_W  generations since last load, saturating
- gen_valid  out  1  1-cycle pulse, high in the cycle after grid changes
- stable  out  1  sticky; next generation equalled current
- extinct  out  1  sticky; grid became all-zero
- busy  out  1  high in RUNNING

Behaviour:
- Reset (async, while reset=0):
  - state=IDLE, grid=0, gen_count=0, tick counter=0, all flags 0.
  - Reset mid-run abandons the current generation with no pending update.
- Next-generation rule:
  - Toroidal neighbourhood: row and column indices wrap mod 8, so row 0 neighbours row 7.
  - Live cell survives with 2 or 3 live neighbours; dead cell is born with exactly 3.
  - Neighbour sum is 4 bits; no other arithmetic.
- load has top priority in every state:
  - On the load edge: grid<=seed, gen_count<=0, tick<=0, stable<=0, extinct<=0, state<=PAUSED, gen_valid<=0.
  - step and run in the same cycle as load are ignored.
- States:
  - IDLE: waits for load; run and step are ignored.
  - PAUSED:
    - run=1 moves to RUNNING on the next edge, with no update that edge.
    - step pulse performs one update (below) at that edge; state stays PAUSED unless the halt rule applies.
  - RUNNING:
    - Tick counter counts 0..TICK_DIV-1; an update fires on the edge where tick==TICK_DIV-1, and tick returns to 0.
    - run=0 moves to PAUSED at the next edge; tick holds its value and resumes from it on re-entry.
    - step is ignored.
  - HALTED: only load or reset exits; run, step and the tick counter are frozen.
- Update at an update edge:
  - If next==grid: grid unchanged, gen_count unchanged, stable<=1, no gen_valid, state<=HALTED.
  - Else if next==0: grid<=0, gen_count++, gen_valid pulse, extinct<=1, state<=HALTED.
  - Else: grid<=next, gen_count++, gen_valid pulse; state unchanged.
- gen_count saturates at all-ones and still updates grid.
- Latency: grid reflects a step pulse in the cycle after the pulse edge; gen_valid is high in that same cycle.
- busy = (state==RUNNING); registered state decode.
- An all-zero seed loads normally; the first update hits next==grid, so stable=1, not extinct.

Decomposition:
- Package life_pkg:
  - typedef enum logic [1:0] {IDLE, PAUSED, RUNNING, HALTED} life_state_t
  - localparams GRID_N=8 and GRID_W=64
  - function cell_idx(r,c) returning r*8+c
- One sub-module, life_next_gen: purely combinational, grid[63:0] in, next[63:0] out, 64 instances of the neighbour-count and rule logic with toroidal wrap.
- The engine holds the FSM, tick counter, registers and flags.

Test Plan (TICK_DIV=4):
- Blinker: load 64'h0000_0000_1C00_0000, one step pulse -> grid=64'h0000_0008_0808_0000, gen_count=1, gen_valid high 1 cycle; a second step returns 64'h0000_0000_1C00_0000, gen_count=2.
- Wrap: load 64'h0000_0000_0000_0083, step -> grid=64'h0100_0000_0000_0101.
- Still life: load 64'h0000_0000_0000_0303, step -> stable=1, state HALTED, gen_count=0, no gen_valid; further step or run cause no change.
- Extinction: load 64'h1, run=1 -> after 4 cycles grid=0, extinct=1, gen_count=1, busy drops; a new load clears the flags.
- Run/pause timing: blinker with run=1 -> gen_valid every 4 cycles. Drop run after 2 ticks of a period, re-raise it 10 cycles later -> next update arrives 2 cycles after re-entry to RUNNING.
- Priority/reset:
  - load with step in the same cycle -> grid=seed, gen_count=0.
  - reset driven low mid-RUNNING -> all outputs 0 immediately, IDLE; step without load is ignored.
